// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divider helper.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } uart_state_t;

    // Clock cycles per oversample tick, truncated, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned d;
        d = clk_freq / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every calc_div() clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8-bit UART receiver, 16x-style oversampling with mid-bit start validation.
// Optional parity stage and PARITY_ERR output enabled by `define UART_RX_PARITY_EN.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 UART_RX,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_STATUS,
    output logic                 RX_BUSY,
    output logic                 FRAME_ERR
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 PARITY_ERR
`endif
);

    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [2:0]     BC_LAST = 3'(DATA_BITS - 1);

    logic                 tick;
    logic                 rx_meta;
    logic                 rx_s;
    uart_state_t          state;
    logic [SCW-1:0]       sc;
    logic [2:0]           bc;
    logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Synchronizer resets to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sc        <= '0;
            bc        <= '0;
            shreg     <= '0;
            RX_DATA   <= '0;
            RX_STATUS <= 1'b0;
            RX_BUSY   <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            PARITY_ERR <= 1'b0;
`endif
        end else begin
            RX_STATUS <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        sc      <= '0;
                        RX_BUSY <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sc == SC_MID) begin
                            sc <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                bc    <= '0;
                            end else begin
                                state   <= IDLE;
                                RX_BUSY <= 1'b0;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            sc        <= '0;
                            shreg[bc] <= rx_s;
                            if (bc == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bc <= bc + 3'd1;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            sc      <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            sc <= '0;
                            if (rx_s) begin
                                state   <= IDLE;
                                RX_BUSY <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                if (par_bit != ((^shreg) ^ PARITY_ODD)) begin
                                    PARITY_ERR <= 1'b1;
                                end else begin
                                    RX_DATA   <= shreg;
                                    RX_STATUS <= 1'b1;
                                end
`else
                                RX_DATA   <= shreg;
                                RX_STATUS <= 1'b1;
`endif
                            end else begin
                                FRAME_ERR <= 1'b1;
                                state     <= WAIT_HI;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                end
                WAIT_HI: begin
                    // A held-low line (break) must not be re-read as a stream of 0x00 frames.
                    if (rx_s) begin
                        state   <= IDLE;
                        RX_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    RX_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule
